// File: rtl/add_scheduler.sv
// -----------------------------------------------------------------------------
// add_scheduler
//
// Time-shares one external WORD-bit carry-lookahead adder slice between two
// requesters. An accepted W-bit add (W = WORD*SLICES) is computed over SLICES
// consecutive passes, least-significant slice first. The carry out of each
// pass is registered and fed back as the carry into the next pass.
//
// Ports
//   clk, rst                    clock and synchronous active-high reset
//   req0_valid/ready/a/b        requester 0 handshake and operands
//   req1_valid/ready/a/b        requester 1 handshake and operands
//   slice_a, slice_b, slice_cin operand slice and carry driven to the CLA slice
//   slice_s, slice_cout         combinational sum/carry returned by the slice
//   res_valid, res_ready        result handshake
//   res_sum, res_cout, res_id   W-bit sum, final carry, owning requester
//
// Timing: a request accepted in cycle N is presented from cycle N+SLICES+1 and
// held until consumed. The block then spends one cycle in idle, giving one add
// every SLICES+2 cycles under continuous demand.
// -----------------------------------------------------------------------------
module add_scheduler #(
   parameter int unsigned WORD   = 16,
   parameter int unsigned SLICES = 2
) (
   input  logic                     clk,
   input  logic                     rst,

   input  logic                     req0_valid,
   output logic                     req0_ready,
   input  logic [WORD*SLICES-1:0]   req0_a,
   input  logic [WORD*SLICES-1:0]   req0_b,

   input  logic                     req1_valid,
   output logic                     req1_ready,
   input  logic [WORD*SLICES-1:0]   req1_a,
   input  logic [WORD*SLICES-1:0]   req1_b,

   output logic [WORD-1:0]          slice_a,
   output logic [WORD-1:0]          slice_b,
   output logic                     slice_cin,
   input  logic [WORD-1:0]          slice_s,
   input  logic                     slice_cout,

   output logic                     res_valid,
   input  logic                     res_ready,
   output logic [WORD*SLICES-1:0]   res_sum,
   output logic                     res_cout,
   output logic                     res_id
);

   localparam int unsigned W    = WORD * SLICES;
   localparam int unsigned IdxW = (SLICES > 1) ? $clog2(SLICES) : 1;
   localparam logic [IdxW-1:0] LastIdx = IdxW'(SLICES - 1);

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StDone
   } state_e;

   // --------------------------------------------------------------------------
   // State
   // --------------------------------------------------------------------------
   state_e          state_q, state_d;
   logic [IdxW-1:0] idx_q,   idx_d;
   logic [W-1:0]    a_q,     a_d;
   logic [W-1:0]    b_q,     b_d;
   logic            id_q,    id_d;
   logic            prio_q,  prio_d;   // 0: requester 0 wins a tie
   logic            carry_q, carry_d;  // carry out of the previous pass
   logic [W-1:0]    sum_q,   sum_d;
   logic            cout_q,  cout_d;

   logic            grant0;
   logic            grant1;

   // --------------------------------------------------------------------------
   // Round-robin arbitration. Ready is only offered in idle, only to a valid
   // requester, and never while reset is asserted.
   // --------------------------------------------------------------------------
   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if ((state_q == StIdle) && !rst) begin
         if (req0_valid && req1_valid) begin
            grant0 = ~prio_q;
            grant1 = prio_q;
         end else begin
            grant0 = req0_valid;
            grant1 = req1_valid;
         end
      end
   end

   assign req0_ready = grant0;
   assign req1_ready = grant1;

   // --------------------------------------------------------------------------
   // Slice datapath: select the current operand slice; everything is zero
   // outside RUN so the shared adder sees quiet inputs.
   // --------------------------------------------------------------------------
   always_comb begin
      slice_a   = '0;
      slice_b   = '0;
      slice_cin = 1'b0;
      if (state_q == StRun) begin
         for (int unsigned i = 0; i < SLICES; i++) begin
            if (idx_q == IdxW'(i)) begin
               slice_a = a_q[i*WORD +: WORD];
               slice_b = b_q[i*WORD +: WORD];
            end
         end
         // The first pass starts a fresh add; later passes chain the carry.
         slice_cin = (idx_q != '0) ? carry_q : 1'b0;
      end
   end

   // --------------------------------------------------------------------------
   // Next-state logic
   // --------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      a_d     = a_q;
      b_d     = b_q;
      id_d    = id_q;
      prio_d  = prio_q;
      carry_d = carry_q;
      sum_d   = sum_q;
      cout_d  = cout_q;

      unique case (state_q)
         StIdle: begin
            if (grant0 || grant1) begin
               a_d     = grant1 ? req1_a : req0_a;
               b_d     = grant1 ? req1_b : req0_b;
               id_d    = grant1;
               // The requester just served loses the next tie.
               prio_d  = grant0;
               idx_d   = '0;
               carry_d = 1'b0;
               state_d = StRun;
            end
         end

         StRun: begin
            for (int unsigned i = 0; i < SLICES; i++) begin
               if (idx_q == IdxW'(i)) begin
                  sum_d[i*WORD +: WORD] = slice_s;
               end
            end
            carry_d = slice_cout;
            if (idx_q == LastIdx) begin
               cout_d  = slice_cout;
               state_d = StDone;
            end else begin
               idx_d = idx_q + IdxW'(1);
            end
         end

         StDone: begin
            // Result registers are untouched here, so the output stays stable
            // until the consumer takes it.
            if (res_ready) begin
               state_d = StIdle;
            end
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // --------------------------------------------------------------------------
   // Registers
   // --------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         idx_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         id_q    <= 1'b0;
         prio_q  <= 1'b0;
         carry_q <= 1'b0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         a_q     <= a_d;
         b_q     <= b_d;
         id_q    <= id_d;
         prio_q  <= prio_d;
         carry_q <= carry_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
      end
   end

   // --------------------------------------------------------------------------
   // Outputs
   // --------------------------------------------------------------------------
   assign res_valid = (state_q == StDone);
   assign res_sum   = sum_q;
   assign res_cout  = cout_q;
   assign res_id    = id_q;

endmodule

// File: tb/tb_add_scheduler.sv
// -----------------------------------------------------------------------------
// tb_add_scheduler
//
// Directed and randomized bench for add_scheduler. The external CLA slice is a
// behavioural adder. Expected values come from whole-word arithmetic on the
// accepted operands plus a two-requester round-robin model.
// -----------------------------------------------------------------------------
module tb_add_scheduler;

   localparam int unsigned WORD   = 16;
   localparam int unsigned SLICES = 2;
   localparam int unsigned W      = WORD * SLICES;

   logic            clk = 1'b0;
   logic            rst;
   logic            req0_valid, req1_valid;
   logic            req0_ready, req1_ready;
   logic [W-1:0]    req0_a, req0_b, req1_a, req1_b;
   logic [WORD-1:0] slice_a, slice_b, slice_s;
   logic            slice_cin, slice_cout;
   logic            res_valid, res_ready;
   logic [W-1:0]    res_sum;
   logic            res_cout, res_id;

   int checks = 0;
   int errors = 0;
   int prio   = 0;   // requester that wins the next tie

   add_scheduler #(
      .WORD   (WORD),
      .SLICES (SLICES)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_a     (req0_a),
      .req0_b     (req0_b),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_a     (req1_a),
      .req1_b     (req1_b),
      .slice_a    (slice_a),
      .slice_b    (slice_b),
      .slice_cin  (slice_cin),
      .slice_s    (slice_s),
      .slice_cout (slice_cout),
      .res_valid  (res_valid),
      .res_ready  (res_ready),
      .res_sum    (res_sum),
      .res_cout   (res_cout),
      .res_id     (res_id)
   );

   // External combinational CLA slice
   assign {slice_cout, slice_s} = {1'b0, slice_a} + {1'b0, slice_b} + {{WORD{1'b0}}, slice_cin};

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One complete transaction from idle. Called 1 time unit after a rising
   // edge; returns at the same phase with the block back in idle.
   task automatic do_add(input bit v0, input bit v1,
                         input logic [W-1:0] a0, input logic [W-1:0] b0,
                         input logic [W-1:0] a1, input logic [W-1:0] b1,
                         input int bp, input bit mutate, input string tag);
      int              g;
      logic [W-1:0]    ea, eb;
      logic [W:0]      exp_full;
      longint unsigned m, lo_a, lo_b;
      logic [WORD-1:0] es_a, es_b;
      logic            exp_cin;

      req0_valid = v0;
      req1_valid = v1;
      req0_a     = a0;
      req0_b     = b0;
      req1_a     = a1;
      req1_b     = b1;
      res_ready  = 1'b0;
      #1;
      if (v0 && v1) g = prio;
      else if (v0)  g = 0;
      else          g = 1;
      chk({tag, ":ready0"}, 64'(req0_ready), 64'(g == 0));
      chk({tag, ":ready1"}, 64'(req1_ready), 64'(g == 1));
      ea       = (g == 1) ? a1 : a0;
      eb       = (g == 1) ? b1 : b0;
      exp_full = {1'b0, ea} + {1'b0, eb};
      prio     = 1 - g;
      tick();

      // Accepted. Optionally scramble the inputs and keep both requesters
      // asking to show the latched copy is used and nothing else is granted.
      if (mutate) begin
         req0_valid = 1'b1;
         req1_valid = 1'b1;
         req0_a     = $urandom;
         req0_b     = $urandom;
         req1_a     = $urandom;
         req1_b     = $urandom;
      end else begin
         req0_valid = 1'b0;
         req1_valid = 1'b0;
      end
      #1;

      for (int k = 0; k < SLICES; k++) begin
         es_a    = WORD'(ea >> (k * WORD));
         es_b    = WORD'(eb >> (k * WORD));
         m       = (64'd1 << (k * WORD)) - 64'd1;
         lo_a    = 64'(ea) & m;
         lo_b    = 64'(eb) & m;
         exp_cin = (k == 0) ? 1'b0 : 1'((lo_a + lo_b) >> (k * WORD));
         chk({tag, ":slice_a"},   64'(slice_a),    64'(es_a));
         chk({tag, ":slice_b"},   64'(slice_b),    64'(es_b));
         chk({tag, ":slice_cin"}, 64'(slice_cin),  64'(exp_cin));
         chk({tag, ":run_valid"}, 64'(res_valid),  64'd0);
         chk({tag, ":run_rdy"},   64'({req0_ready, req1_ready}), 64'd0);
         tick();
      end

      for (int c = 0; c <= bp; c++) begin
         res_ready = (c == bp);
         #1;
         chk({tag, ":res_valid"}, 64'(res_valid), 64'd1);
         chk({tag, ":res_sum"},   64'(res_sum),   64'(exp_full[W-1:0]));
         chk({tag, ":res_cout"},  64'(res_cout),  64'(exp_full[W]));
         chk({tag, ":res_id"},    64'(res_id),    64'(g));
         chk({tag, ":done_rdy"},  64'({req0_ready, req1_ready}), 64'd0);
         chk({tag, ":done_quiet"}, 64'({slice_a, slice_b, slice_cin}), 64'd0);
         tick();
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      res_ready  = 1'b0;
      #1;
      chk({tag, ":consumed"}, 64'(res_valid), 64'd0);
   endtask

   initial begin
      int          gc[$];
      int          gid[$];
      int          v;
      logic [W-1:0] ra0, rb0, ra1, rb1;

      rst        = 1'b1;
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      req0_a     = 32'h1111_2222;
      req0_b     = 32'h3333_4444;
      req1_a     = 32'h5555_6666;
      req1_b     = 32'h7777_8888;
      res_ready  = 1'b1;
      tick();
      tick();
      #1;
      chk("rst:ready0",    64'(req0_ready), 64'd0);
      chk("rst:ready1",    64'(req1_ready), 64'd0);
      chk("rst:res_valid", 64'(res_valid),  64'd0);
      chk("rst:res_sum",   64'(res_sum),    64'd0);
      chk("rst:res_cout",  64'(res_cout),   64'd0);
      chk("rst:res_id",    64'(res_id),     64'd0);
      chk("rst:slice",     64'({slice_a, slice_b, slice_cin}), 64'd0);

      // Contention from reset: both always valid, results always accepted.
      rst = 1'b0;
      for (int cyc = 0; cyc < 16; cyc++) begin
         #1;
         chk("cont:one_ready", 64'(req0_ready && req1_ready), 64'd0);
         if (req0_ready) begin gc.push_back(cyc); gid.push_back(0); end
         if (req1_ready) begin gc.push_back(cyc); gid.push_back(1); end
         tick();
      end
      chk("cont:grants", 64'(gc.size()), 64'd4);
      for (int i = 0; i < gc.size() && i < 4; i++) begin
         chk("cont:order", 64'(gid[i]), 64'(i % 2));
         if (i > 0) chk("cont:spacing", 64'(gc[i] - gc[i-1]), 64'(SLICES + 2));
      end

      rst        = 1'b1;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      tick();
      rst  = 1'b0;
      prio = 0;
      tick();

      do_add(1'b1, 1'b0, 32'h0000_FFFF, 32'h0000_0001, 32'h0, 32'h0, 0, 1'b0, "single");
      do_add(1'b0, 1'b1, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'h0000_0001, 0, 1'b0, "overflow");
      do_add(1'b1, 1'b1, 32'h8000_FFFF, 32'h8000_0001, 32'h1234_5678, 32'h1, 5, 1'b0,
             "backpressure");

      // The requester that lost the tie dropped valid: nothing more happens.
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("dropped:ready", 64'({req0_ready, req1_ready}), 64'd0);
         chk("dropped:valid", 64'(res_valid), 64'd0);
      end

      do_add(1'b1, 1'b0, 32'hDEAD_BEEF, 32'h2152_4111, 32'h0, 32'h0, 1, 1'b1, "mutate");

      // Reset during the second pass abandons the add.
      req0_valid = 1'b1;
      req0_a     = 32'h0FFF_FFFF;
      req0_b     = 32'h0000_0001;
      #1;
      chk("midrst:accept", 64'(req0_ready), 64'd1);
      tick();
      req0_valid = 1'b0;
      tick();
      rst        = 1'b1;
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      #1;
      chk("midrst:ready", 64'({req0_ready, req1_ready}), 64'd0);
      tick();
      rst        = 1'b0;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      prio       = 0;
      for (int i = 0; i < 6; i++) begin
         #1;
         chk("midrst:no_result", 64'(res_valid), 64'd0);
         tick();
      end
      do_add(1'b1, 1'b0, 32'h0001_8000, 32'h0000_8000, 32'h0, 32'h0, 0, 1'b0, "after_rst");

      // Randomized traffic
      for (int n = 0; n < 40; n++) begin
         v   = $urandom_range(1, 3);
         ra0 = $urandom;
         rb0 = $urandom;
         ra1 = $urandom;
         rb1 = $urandom;
         if ($urandom_range(0, 3) == 0) begin
            ra0 = '1;
            rb0 = 32'h1;
         end
         do_add(v[0], v[1], ra0, rb0, ra1, rb1, $urandom_range(0, 3),
                1'($urandom_range(0, 1)), "rand");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/add_scheduler.md
ADD_SCHEDULER -- requirements
Module: add_scheduler

Interface
REQ-001 Parameter WORD, default 16, SHALL be the slice width in bits of the shared CLA adder.
REQ-002 Parameter SLICES, default 2, SHALL be the number of slice passes per add; operand width W = WORD*SLICES (32 at default).
REQ-003 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  in  1  SHALL be the synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 req0_valid, req1_valid  in  1 each  SHALL flag a pending add request from requester 0 or 1.
REQ-006 req0_a, req0_b, req1_a, req1_b  in  W each  SHALL be the requesters' operands.
REQ-007 req0_ready, req1_ready  out  1 each  SHALL grant acceptance; a request transfers when valid and ready are both high.
REQ-008 slice_a, slice_b  out  WORD each  SHALL be the operand slices driven to the external CLA slice.
REQ-009 slice_cin  out  1  SHALL be the carry-in driven to the slice.
REQ-010 slice_s  in  WORD, slice_cout  in  1  SHALL be the slice's combinational sum and carry-out, valid in the same cycle.
REQ-011 res_valid  out  1  SHALL flag a completed result; res_ready  in  1  SHALL be the consumer's acceptance.
REQ-012 res_sum  out  W, res_cout  out  1, res_id  out  1  SHALL be the sum, final carry-out and owning requester.

Function
REQ-013 States SHALL be IDLE, RUN, DONE; nothing else is reachable.
REQ-014 In IDLE, at most one reqN_ready SHALL be high, and only when reqN_valid is high (ready depends on valid).
REQ-015 Arbitration SHALL be round-robin: with one valid request, grant it; with both valid, grant the requester not granted last.
REQ-016 On acceptance the block SHALL latch both operands and the requester id, clear the slice index to 0, and enter RUN.
REQ-017 Operand changes after acceptance SHALL have no effect on the result.
REQ-018 In RUN with slice index k, slice_a/slice_b SHALL carry bits [k*WORD +: WORD] of the latched operands, least-significant slice first.
REQ-019 slice_cin SHALL be 0 for k=0 and the registered slice_cout of pass k-1 for k>0.
REQ-020 Each RUN cycle SHALL store slice_s into res_sum bits [k*WORD +: WORD] and register slice_cout.
REQ-021 After pass k=SLICES-1 the block SHALL enter DONE with res_cout equal to that pass's slice_cout.
REQ-022 Latency SHALL be fixed: acceptance in cycle N produces res_valid high from cycle N+SLICES+1.
REQ-023 In DONE, res_valid, res_sum, res_cout and res_id SHALL hold stable until res_valid and res_ready are both high; then the block SHALL enter IDLE.
REQ-024 Both reqN_ready outputs SHALL be low in RUN and DONE; no new request is accepted in the cycle the result is consumed.
REQ-025 Outside RUN, slice_a, slice_b and slice_cin SHALL be 0.
REQ-026 Arithmetic SHALL be modulo 2^W, with overflow reported only through res_cout; all-ones plus 1 gives res_sum 0, res_cout 1.
REQ-027 A requester that drops valid before being granted SHALL simply not be served, with no state change.
REQ-028 Throughput SHALL be one add per SLICES+2 cycles when res_ready is held high.

Reset
REQ-029 When rst is high, state SHALL become IDLE and the slice index 0.
REQ-030 When rst is high, res_valid, res_sum, res_cout, res_id and the registered carry SHALL become 0, and the round-robin pointer SHALL give requester 0 priority.
REQ-031 When rst is high, reqN_ready SHALL be low in that cycle.
REQ-032 rst asserted in RUN or DONE SHALL abandon the operation; no result for it is ever presented.

Verification
REQ-033 Single add: req0 a=0x0000FFFF, b=0x00000001 -> one cycle later slice_cin=1 on pass 1; res_sum=0x00010000, res_cout=0, res_id=0 at cycle N+3.
REQ-034 Overflow: req1 a=0xFFFFFFFF, b=0x00000001 -> res_sum=0x00000000, res_cout=1, res_id=1.
REQ-035 Contention: both valid continuously from reset with res_ready=1 -> grant order 0,1,0,1; each grant 4 cycles apart.
REQ-036 Backpressure: res_ready=0 for 5 cycles after res_valid -> result held stable, both ready outputs low; completes on the first cycle res_ready=1.
REQ-037 Reset mid-op: rst pulsed during RUN pass 1 -> res_valid never rises for that request; next request accepted from IDLE gives the correct sum.
REQ-038 Operand mutation: req0 a/b changed the cycle after acceptance -> result reflects the originally latched values.
